// File: rtl/md_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide unit.
package md_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DIV_FIX
  } md_state_e;
endpackage

// File: rtl/md_unit_div_core.sv
// Unsigned 32-bit restoring divider, one quotient bit per step, MSB first.
module div_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  logic [31:0] r_q;
  logic [31:0] r_r;
  logic [31:0] r_d;
  logic [32:0] w_sh;
  logic [32:0] w_diff;
  logic        w_ge;

  // r_q shifts dividend bits out the top while quotient bits enter below
  assign w_sh   = {r_r, r_q[31]};
  assign w_diff = w_sh - {1'b0, r_d};
  assign w_ge   = ~w_diff[32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      r_r <= '0;
      r_d <= '0;
    end else if (load) begin
      r_q <= dividend;
      r_r <= '0;
      r_d <= divisor;
    end else if (step) begin
      r_q <= {r_q[30:0], w_ge};
      r_r <= w_ge ? w_diff[31:0] : w_sh[31:0];
    end
  end

  assign quotient  = r_q;
  assign remainder = r_r;
endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO pair.
module md_unit #(
  parameter int MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import md_pkg::*;

  md_state_e   r_state;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sgn;
  logic        r_sa;
  logic        r_sb;
  logic [5:0]  r_cnt;

  logic        w_accept;
  logic        w_sdiv;
  logic        w_sa;
  logic        w_sb;
  logic        w_load;
  logic        w_step;
  logic [31:0] w_amag;
  logic [31:0] w_bmag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_lo_div;
  logic [31:0] w_hi_div;
  logic [63:0] w_ea;
  logic [63:0] w_eb;
  logic [63:0] w_prod;

  assign w_accept = (r_state == IDLE) & start & ~cancel;
  assign w_sdiv   = (op == MD_DIV);
  assign w_sa     = w_sdiv & a[31];
  assign w_sb     = w_sdiv & b[31];
  assign w_load   = w_accept & ((op == MD_DIV) | (op == MD_DIVU));
  assign w_step   = (r_state == DIV) & ~cancel;
  assign w_amag   = w_sa ? -a : a;
  assign w_bmag   = w_sb ? -b : b;

  div_core u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .step      (w_step),
    .dividend  (w_amag),
    .divisor   (w_bmag),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  // 64-bit extension makes one unsigned multiply serve both signednesses
  assign w_ea   = {{32{r_sgn & r_a[31]}}, r_a};
  assign w_eb   = {{32{r_sgn & r_b[31]}}, r_b};
  assign w_prod = w_ea * w_eb;

  assign w_lo_div = (r_sa ^ r_sb) ? -w_quo : w_quo;
  assign w_hi_div = r_sa ? -w_rem : w_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (cancel && r_state != IDLE) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_accept) begin
              unique case (op)
                MD_MULT, MD_MULTU: begin
                  r_a     <= a;
                  r_b     <= b;
                  r_sgn   <= (op == MD_MULT);
                  r_cnt   <= 6'(MUL_CYCLES - 1);
                  r_state <= MUL;
                  r_busy  <= 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                  r_a     <= a;
                  r_b     <= b;
                  r_sa    <= w_sa;
                  r_sb    <= w_sb;
                  r_cnt   <= '0;
                  r_state <= DIV;
                  r_busy  <= 1'b1;
                end
                MD_MTHI: r_hi <= a;
                MD_MTLO: r_lo <= a;
                default: ;
              endcase
            end
          end
          MUL: begin
            if (r_cnt == '0) begin
              r_hi    <= w_prod[63:32];
              r_lo    <= w_prod[31:0];
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt - 6'd1;
            end
          end
          DIV: begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'(DIV_STEPS - 1)) r_state <= DIV_FIX;
          end
          DIV_FIX: begin
            // zero divisor commits the raw dividend, bypassing sign fix
            if (r_b == '0) begin
              r_hi <= r_a;
              r_lo <= '1;
            end else begin
              r_hi <= w_hi_div;
              r_lo <= w_lo_div;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit with a behavioural HI/LO reference model.
module tb_md_unit;
  localparam int MC = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  md_unit #(.MUL_CYCLES(MC)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] o, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] eh,
                                output logic [31:0] el);
    longint          p;
    longint unsigned pu;
    int              sx;
    int              sy;
    eh = 0;
    el = 0;
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {eh, el} = p;
      end
      3'd1: begin
        pu = 64'(x) * 64'(y);
        {eh, el} = pu;
      end
      3'd2: begin
        if (y == 0) begin
          eh = x; el = 32'hFFFFFFFF;
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          eh = 0; el = 32'h80000000;
        end else begin
          sx = x; sy = y;
          el = 32'(sx / sy);
          eh = 32'(sx % sy);
        end
      end
      default: begin
        if (y == 0) begin
          eh = x; el = 32'hFFFFFFFF;
        end else begin
          el = x / y;
          eh = x % y;
        end
      end
    endcase
  endfunction

  // caller sits at a negedge; returns busy cycles and done pulses seen
  task automatic do_op(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int bc, output int dc);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 80; i++) begin
      if (busy) bc++;
      if (done) dc++;
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 0; a = 0; b = 0;
    #12;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b want 00", {busy, done});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++; $display("FAIL reset_hilo: got %h want 0", {hi, lo});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int bc, dc;
    do_op(3'd0, 32'hFFFFFFFD, 32'd7, bc, dc);
    checks++;
    if (bc !== MC) begin errors++; $display("FAIL mult_busy: got %0d want %0d", bc, MC); end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL mult_done: got %0d want 1", dc); end
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      errors++; $display("FAIL mult_result: got %h want ffffffffffffffeb", {hi, lo});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL mult_pulse: got %b want 0", done); end
  endtask

  task automatic test_multu_b2b();
    int bc, dc;
    do_op(3'd1, 32'hFFFFFFFF, 32'd2, bc, dc);
    checks++;
    if ({hi, lo} !== 64'h00000001_FFFFFFFE || dc !== 1) begin
      errors++; $display("FAIL multu_result: got %h/%0d want 00000001fffffffe/1", {hi, lo}, dc);
    end
    do_op(3'd1, 32'h00010000, 32'h00030000, bc, dc);
    checks++;
    if (bc !== MC || dc !== 1) begin
      errors++; $display("FAIL b2b_accept: got busy %0d done %0d want %0d/1", bc, dc, MC);
    end
    checks++;
    if ({hi, lo} !== 64'h00000003_00000000) begin
      errors++; $display("FAIL b2b_result: got %h want 0000000300000000", {hi, lo});
    end
  endtask

  task automatic test_div();
    int bc, dc;
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, bc, dc);
    checks++;
    if (bc !== 33 || dc !== 1) begin
      errors++; $display("FAIL div_timing: got busy %0d done %0d want 33/1", bc, dc);
    end
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_signed: got hi %h lo %h want ffffffff/fffffffd", hi, lo);
    end
    do_op(3'd3, 32'd100, 32'd7, bc, dc);
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++; $display("FAIL divu: got hi %0d lo %0d want 2/14", hi, lo);
    end
  endtask

  task automatic test_div_special();
    int bc, dc;
    do_op(3'd3, 32'd100, 32'd0, bc, dc);
    checks++;
    if (bc !== 33 || hi !== 32'd100 || lo !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_zero: got busy %0d hi %h lo %h want 33/64/ffffffff", bc, hi, lo);
    end
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, bc, dc);
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'h0) begin
      errors++; $display("FAIL div_ovf: got hi %h lo %h want 0/80000000", hi, lo);
    end
  endtask

  task automatic test_random();
    int bc, dc, sel;
    logic [2:0]  o;
    logic [31:0] x, y, eh, el;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      sel = $urandom_range(0, 5);
      y = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) :
          (sel == 2) ? 32'hFFFFFFFF : $urandom;
      model(o, x, y, eh, el);
      do_op(o, x, y, bc, dc);
      checks++;
      if (bc !== ((o < 2) ? MC : 33) || dc !== 1) begin
        errors++; $display("FAIL rand_timing op%0d: got busy %0d done %0d", o, bc, dc);
      end
      checks++;
      if (hi !== eh || lo !== el) begin
        errors++;
        $display("FAIL rand_result op%0d a=%h b=%h: got %h_%h want %h_%h", o, x, y, hi, lo, eh, el);
      end
    end
  endtask

  task automatic test_cancel();
    int bc, dc, nd, nb;
    do_op(3'd4, 32'hAAAA5555, 32'd0, bc, dc);
    do_op(3'd5, 32'h5A5A5A5A, 32'd0, bc, dc);
    start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'h11111111;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 3'd6; a = 32'h22222222;
    checks++;
    if (busy !== 1'b0 || hi !== 32'hAAAA5555) begin
      errors++; $display("FAIL idle_cancel: got busy %b hi %h want 0/aaaa5555", busy, hi);
    end
    start = 1'b1;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'hAAAA5555 || lo !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL bad_op: got busy %b hi %h lo %h", busy, hi, lo);
    end
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL inflight: got busy %b want 1", busy); end
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL cancel_edge: got busy %b done %b want 0/0", busy, done);
    end
    nd = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    checks++;
    if (nd !== 0 || nb !== 0) begin
      errors++; $display("FAIL cancel_quiet: got done %0d busy %0d want 0/0", nd, nb);
    end
    checks++;
    if (hi !== 32'hAAAA5555 || lo !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL cancel_hilo: got %h_%h want aaaa5555_5a5a5a5a", hi, lo);
    end
  endtask

  task automatic test_mthi_rst();
    int bc, dc;
    start = 1'b1; op = 3'd4; a = 32'h12345678;
    @(posedge clk);
    #1;
    checks++;
    if (hi !== 32'h12345678 || busy !== 1'b0) begin
      errors++; $display("FAIL mthi: got hi %h busy %b want 12345678/0", hi, busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mthi_flags: got %b%b want 00", busy, done);
    end
    start = 1'b1; op = 3'd2; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL async_rst: got busy %b done %b hi %h lo %h", busy, done, hi, lo);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(3'd3, 32'd9, 32'd3, bc, dc);
    checks++;
    if (bc !== 33 || lo !== 32'd3 || hi !== 32'd0) begin
      errors++; $display("FAIL post_rst_div: got busy %0d hi %0d lo %0d want 33/0/3", bc, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_b2b();
    test_div();
    test_div_special();
    test_random();
    test_cancel();
    test_mthi_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
